// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
//   uart_state_t : 2-bit FSM state encoding (IDLE, START, DATA, STOP)
//   OVERSAMPLE   : ticks per bit at the 16x oversampling rate
//   MID_SAMPLE   : tick index of the middle of the start bit
//   TICK_CNT_W   : width of the per-bit tick counter (covers up to 2 stop bits)
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;
  localparam int unsigned TICK_CNT_W = 5;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
//   i_clk   : destination clock
//   i_reset : synchronous active-high reset, loads RESET_VAL into both flops
//   i_d     : asynchronous input
//   o_q     : synchronized output (2 cycles of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= RESET_VAL;
      o_q    <= RESET_VAL;
    end else begin
      meta_q <= i_d;
      o_q    <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 1 start bit, NB_DATA data bits LSB first,
// SB_TICK/16 stop bits, no parity.
//   i_clk          : system clock
//   i_reset        : synchronous active-high reset
//   i_rx           : asynchronous serial line, idle high
//   i_s_tick       : one-cycle pulse at 16x the baud rate
//   o_rx_done_tick : one-cycle pulse when a frame completes (o_data valid)
//   o_data         : last received word, held until the next frame completes
//   o_frame_err    : stop bit of the last frame was sampled low
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx,
  input  logic               i_s_tick,
  output logic               o_rx_done_tick,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_frame_err
);

  localparam int unsigned N_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [TICK_CNT_W-1:0] S_MID  = TICK_CNT_W'(MID_SAMPLE);
  localparam logic [TICK_CNT_W-1:0] S_BIT  = TICK_CNT_W'(OVERSAMPLE - 1);
  localparam logic [TICK_CNT_W-1:0] S_STOP = TICK_CNT_W'(SB_TICK - 1);
  localparam logic [N_W-1:0]        N_LAST = N_W'(NB_DATA - 1);

  logic rx_s;

  uart_state_t             state_q, state_d;
  logic [TICK_CNT_W-1:0]   s_q, s_d;
  logic [N_W-1:0]          n_q, n_d;
  logic [NB_DATA-1:0]      shreg_q, shreg_d;
  logic [NB_DATA-1:0]      data_d;
  logic                    ferr_d;
  logic                    done_d;

  // Line synchronizer; resets to 1 so reset never looks like a start bit.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= IDLE;
      s_q            <= '0;
      n_q            <= '0;
      shreg_q        <= '0;
      o_data         <= '0;
      o_frame_err    <= 1'b0;
      o_rx_done_tick <= 1'b0;
    end else begin
      state_q        <= state_d;
      s_q            <= s_d;
      n_q            <= n_d;
      shreg_q        <= shreg_d;
      o_data         <= data_d;
      o_frame_err    <= ferr_d;
      o_rx_done_tick <= done_d;
    end
  end

  // Next-state logic; counters only move on ticks, except IDLE->START.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    data_d  = o_data;
    ferr_d  = o_frame_err;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (i_s_tick) begin
          if (s_q == S_MID) begin
            // Line back high at mid start bit: treat as a glitch.
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + TICK_CNT_W'(1);
          end
        end
      end

      DATA: begin
        if (i_s_tick) begin
          if (s_q == S_BIT) begin
            shreg_d = {rx_s, shreg_q[NB_DATA-1:1]};
            s_d     = '0;
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + TICK_CNT_W'(1);
          end
        end
      end

      STOP: begin
        if (i_s_tick) begin
          if (s_q == S_STOP) begin
            // Leave at mid stop bit so a following start edge is not missed.
            data_d  = shreg_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + TICK_CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: baud tick generator, serial line driver, and a scoreboard
// that compares every done pulse against the expected word queue.
module tb_uart_rx;

  localparam int unsigned NB_DATA = 8;

  typedef struct {
    logic [NB_DATA-1:0] data;
    logic               ferr;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               rx = 1'b1;
  logic               s_tick = 1'b0;
  logic               done;
  logic [NB_DATA-1:0] data;
  logic               ferr;

  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   baud_mod = 163;
  int   tick_cnt = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  uart_rx #(
    .NB_DATA (NB_DATA),
    .SB_TICK (16)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_rx           (rx),
    .i_s_tick       (s_tick),
    .o_rx_done_tick (done),
    .o_data         (data),
    .o_frame_err    (ferr)
  );

  // 50 MHz clock.
  always #10 clk = ~clk;

  // Baud tick generator: one pulse every baud_mod clocks.
  always_ff @(posedge clk) begin
    if (tick_cnt >= baud_mod - 1) begin
      tick_cnt <= 0;
      s_tick   <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1;
      s_tick   <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_bits(input int bit_cyc, input int nbits);
    rx = 1'b1;
    repeat (bit_cyc * nbits) @(negedge clk);
  endtask

  // Drive one frame; a low stop bit is released after 3/4 of the bit time.
  task automatic send_frame(input logic [NB_DATA-1:0] d, input int bit_cyc, input bit stop_low);
    exp_t e;
    e.data = d;
    e.ferr = stop_low;
    exp_q.push_back(e);
    rx = 1'b0;
    repeat (bit_cyc) @(negedge clk);
    for (int i = 0; i < NB_DATA; i++) begin
      rx = d[i];
      repeat (bit_cyc) @(negedge clk);
    end
    if (stop_low) begin
      rx = 1'b0;
      repeat ((bit_cyc * 3) / 4) @(negedge clk);
      rx = 1'b1;
      repeat (bit_cyc - (bit_cyc * 3) / 4) @(negedge clk);
    end else begin
      rx = 1'b1;
      repeat (bit_cyc) @(negedge clk);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (done) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: data 0x%0h ferr %0b with no frame pending at %0t",
                 data, ferr, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_data", 32'(data), 32'(mon_e.data));
        check("frame_err", 32'(ferr), 32'(mon_e.ferr));
      end
    end
  end

  initial begin
    int bit_cyc;
    int wait_cyc;

    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_data", 32'(data), 32'h0);
    check("reset_ferr", 32'(ferr), 32'h0);
    check("reset_done", 32'(done), 32'h0);

    // 19200 baud from 50 MHz.
    bit_cyc = 16 * baud_mod;
    idle_bits(bit_cyc, 1);
    send_frame(8'h55, bit_cyc, 1'b0);
    idle_bits(bit_cyc, 1);

    // Faster tick for the remaining frames.
    baud_mod = 10;
    bit_cyc  = 16 * baud_mod;
    idle_bits(bit_cyc, 2);

    // Back-to-back frames with no idle bit.
    send_frame(8'hA3, bit_cyc, 1'b0);
    send_frame(8'h0F, bit_cyc, 1'b0);
    idle_bits(bit_cyc, 2);

    // Short low glitch on an idle line.
    rx = 1'b0;
    repeat (3 * baud_mod) @(negedge clk);
    idle_bits(bit_cyc, 2);
    check("glitch_data_held", 32'(data), 32'h0F);
    check("pulses_after_glitch", 32'(pulses), 32'd3);

    // Frame error, then a good frame clears the flag.
    send_frame(8'hC4, bit_cyc, 1'b1);
    idle_bits(bit_cyc, 2);
    check("ferr_held", 32'(ferr), 32'h1);
    send_frame(8'h12, bit_cyc, 1'b0);
    idle_bits(bit_cyc, 2);

    // Reset in the middle of data bit 4 of 0xFF.
    rx = 1'b0;
    repeat (bit_cyc) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      repeat (bit_cyc) @(negedge clk);
    end
    repeat (bit_cyc / 2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_data", 32'(data), 32'h0);
    check("abort_ferr", 32'(ferr), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    idle_bits(bit_cyc, 6);
    check("pulses_after_abort", 32'(pulses), 32'd5);
    send_frame(8'h81, bit_cyc, 1'b0);
    idle_bits(bit_cyc, 2);

    // +/-3% baud offset on the line.
    send_frame(8'h00, 165, 1'b0);
    idle_bits(bit_cyc, 2);
    send_frame(8'hFF, 155, 1'b0);
    idle_bits(bit_cyc, 2);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 2000) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("frames_pending", 32'(exp_q.size()), 32'd0);
    check("total_pulses", 32'(pulses), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
